// File: rtl/decision_display_ctrl_pkg.sv
// Shared constants for the decision LED presenter: FSM state codes,
// the "no decision" code and the default timing values.
package decision_display_ctrl_pkg;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_FLASH_ON  = 2'd1;
    localparam logic [1:0] S_FLASH_OFF = 2'd2;
    localparam logic [1:0] S_SHOW      = 2'd3;

    localparam int DEC_NONE = 0;

    localparam int DEF_HOLD_CYC   = 100_000_000;
    localparam int DEF_BLINK_HALF = 25_000_000;
    localparam int DEF_FLASH_N    = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/decision_display_ctrl_phase_timer.sv
// Phase timer: up-counter restarted on every phase entry; `expired` is a
// registered flag that is high while the count sits at limit-1.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    // limit==0 means "never expire": the count freezes so it cannot wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (restart) begin
            count   <= '0;
            expired <= (limit == W'(1));
        end else if (limit == '0) begin
            expired <= 1'b0;
        end else begin
            count   <= count + W'(1);
            expired <= ((count + W'(2)) == limit);
        end
    end

endmodule

// File: rtl/decision_display_ctrl.sv
// Registered LED presenter: latches the decision code on ans_done, optionally
// flashes it, holds it steady for a while, then blanks the LEDs.
module decision_display_ctrl
    import decision_display_ctrl_pkg::*;
#(
    parameter int ANS_W      = 3,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int BLINK_HALF = DEF_BLINK_HALF,
    parameter int FLASH_N    = DEF_FLASH_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ANS_W-1:0] ans_in,
    input  logic             ans_done,
    input  logic             flash_en,
    input  logic             clear,
    output logic [ANS_W-1:0] led_out,
    output logic             busy,
    output logic [ANS_W-1:0] ans_q
);

    localparam int TW = $clog2(max_int(HOLD_CYC, BLINK_HALF) + 1);
    localparam int FW = (FLASH_N > 0) ? $clog2(FLASH_N + 1) : 1;
    localparam logic [TW-1:0] HOLD_LIM  = TW'(HOLD_CYC);
    localparam logic [TW-1:0] BLINK_LIM = TW'(BLINK_HALF);

    logic [1:0]       state, state_d;
    logic [FW-1:0]    fcnt, fcnt_d;
    logic [ANS_W-1:0] ans_d;
    logic             start, restart, expired;
    logic [TW-1:0]    limit;

    // A zero code lights every LED so "no decision" is still visible
    function automatic logic [ANS_W-1:0] led_pattern(input logic [ANS_W-1:0] code,
                                                     input logic [1:0] st);
        if (st == S_FLASH_ON || st == S_SHOW)
            return (code == ANS_W'(DEC_NONE)) ? '1 : code;
        return '0;
    endfunction

    always_comb begin
        start   = ans_done & ~clear;
        state_d = state;
        fcnt_d  = fcnt;
        ans_d   = ans_q;
        if (clear) begin
            state_d = S_IDLE;
            fcnt_d  = '0;
        end else if (ans_done) begin
            ans_d   = ans_in;
            fcnt_d  = '0;
            state_d = ((flash_en || ans_in == ANS_W'(DEC_NONE)) && FLASH_N > 0)
                      ? S_FLASH_ON : S_SHOW;
        end else if (expired) begin
            case (state)
                S_FLASH_ON:  state_d = S_FLASH_OFF;
                S_FLASH_OFF: begin
                    fcnt_d  = fcnt + FW'(1);
                    state_d = ((fcnt + FW'(1)) == FW'(FLASH_N)) ? S_SHOW : S_FLASH_ON;
                end
                S_SHOW:      state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // The timer sees the limit of the phase being entered so its first
    // expiry decision after a restart already uses the right length
    always_comb begin
        restart = start | (state_d != state);
        case (state_d)
            S_FLASH_ON, S_FLASH_OFF: limit = BLINK_LIM;
            S_SHOW:                  limit = HOLD_LIM;
            default:                 limit = '0;
        endcase
    end

    phase_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .limit   (limit),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            fcnt    <= '0;
            ans_q   <= '0;
            led_out <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            fcnt    <= fcnt_d;
            ans_q   <= ans_d;
            led_out <= led_pattern(ans_d, state_d);
            busy    <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_decision_display_ctrl.sv
// Bench for decision_display_ctrl: directed table, corner sequences and
// random traffic checked against a schedule-based reference model.
module tb_decision_display_ctrl;

    localparam int HOLD  = 8;
    localparam int BLINK = 2;
    localparam int FN    = 2;

    logic       clk = 1'b0;
    logic       rst, ans_done, flash_en, clear;
    logic [2:0] ans_in;
    logic [2:0] led8, q8a, led0, q0a;
    logic       busy8, busy0;

    always #5 clk = ~clk;

    decision_display_ctrl #(.ANS_W(3), .HOLD_CYC(HOLD), .BLINK_HALF(BLINK), .FLASH_N(FN)) dut (
        .clk(clk), .rst(rst), .ans_in(ans_in), .ans_done(ans_done), .flash_en(flash_en),
        .clear(clear), .led_out(led8), .busy(busy8), .ans_q(q8a)
    );

    decision_display_ctrl #(.ANS_W(3), .HOLD_CYC(0), .BLINK_HALF(BLINK), .FLASH_N(FN)) dut_h0 (
        .clk(clk), .rst(rst), .ans_in(ans_in), .ans_done(ans_done), .flash_en(flash_en),
        .clear(clear), .led_out(led0), .busy(busy0), .ans_q(q0a)
    );

    int total = 0;
    int bad   = 0;

    // Model: each accepted decision becomes a list of future {busy,led} values
    typedef logic [3:0] ent_t;
    ent_t       m8[$];
    ent_t       m0[$];
    logic       inf0;
    logic [2:0] pat0, mq;
    ent_t       e8, e0;

    typedef struct {
        logic       ad;
        logic [2:0] ain;
        logic       fe;
        logic       clr;
        logic [2:0] led;
        logic       busy;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m8.delete();
        m0.delete();
        inf0 = 1'b0;
        pat0 = 3'b000;
        mq   = 3'b000;
        e8   = '0;
        e0   = '0;
    endtask

    task automatic model_edge(input logic ad, input logic [2:0] ain, input logic fe, input logic clr);
        logic [2:0] pat;
        if (clr) begin
            m8.delete();
            m0.delete();
            inf0 = 1'b0;
        end else if (ad) begin
            mq  = ain;
            pat = (ain == 3'b000) ? 3'b111 : ain;
            m8.delete();
            m0.delete();
            inf0 = 1'b1;
            pat0 = pat;
            if (fe || ain == 3'b000) begin
                for (int i = 0; i < FN; i++) begin
                    for (int j = 0; j < BLINK; j++) begin
                        m8.push_back({1'b1, pat});
                        m0.push_back({1'b1, pat});
                    end
                    for (int j = 0; j < BLINK; j++) begin
                        m8.push_back({1'b1, 3'b000});
                        m0.push_back({1'b1, 3'b000});
                    end
                end
            end
            for (int i = 0; i < HOLD; i++) m8.push_back({1'b1, pat});
        end else begin
            if (m8.size() > 0) void'(m8.pop_front());
            if (m0.size() > 0) void'(m0.pop_front());
        end
        e8 = (m8.size() > 0) ? m8[0] : 4'b0000;
        e0 = (m0.size() > 0) ? m0[0] : (inf0 ? {1'b1, pat0} : 4'b0000);
    endtask

    task automatic check_all();
        chk("led", 8'(led8), 8'(e8[2:0]));
        chk("busy", 8'(busy8), 8'(e8[3]));
        chk("ans_q", 8'(q8a), 8'(mq));
        chk("h0_busy_led", 8'({busy0, led0}), 8'(e0));
        chk("h0_ans_q", 8'(q0a), 8'(mq));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, check
    task automatic cyc(input logic ad, input logic [2:0] ain, input logic fe, input logic clr);
        ans_done = ad;
        ans_in   = ain;
        flash_en = fe;
        clear    = clr;
        @(posedge clk);
        model_edge(ad, ain, fe, clr);
        @(negedge clk);
        check_all();
        ans_done = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic add(input logic ad, input logic [2:0] ain, input logic fe, input logic clr,
                       input logic [2:0] led, input logic busy);
        tbl.push_back('{ad, ain, fe, clr, led, busy});
    endtask

    task automatic add_flash(input logic [2:0] led);
        for (int k = 0; k < FN; k++) begin
            if (k > 0) begin
                add(0, 0, 0, 0, led, 1);
                add(0, 0, 0, 0, led, 1);
            end else begin
                add(0, 0, 0, 0, led, 1);
            end
            add(0, 0, 0, 0, 3'b000, 1);
            add(0, 0, 0, 0, 3'b000, 1);
        end
        for (int k = 0; k < 8; k++) add(0, 0, 0, 0, led, 1);
        add(0, 0, 0, 0, 3'b000, 0);
    endtask

    initial begin
        rst = 1'b1; ans_done = 1'b0; ans_in = 3'b000; flash_en = 1'b0; clear = 1'b0;
        model_reset();

        // Directed vectors: plain show, flash of 011, forced flash of zero code
        add(1, 3'b101, 0, 0, 3'b101, 1);
        for (int k = 0; k < 7; k++) add(0, 0, 0, 0, 3'b101, 1);
        add(0, 0, 0, 0, 3'b000, 0);
        add(0, 0, 0, 0, 3'b000, 0);
        add(1, 3'b011, 1, 0, 3'b011, 1);
        add_flash(3'b011);
        add(1, 3'b000, 0, 0, 3'b111, 1);
        add_flash(3'b111);
        add(0, 0, 0, 0, 3'b000, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        cyc(0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].ad, tbl[i].ain, tbl[i].fe, tbl[i].clr);
            chk("tbl_led", 8'(led8), 8'(tbl[i].led));
            chk("tbl_busy", 8'(busy8), 8'(tbl[i].busy));
        end
        chk("zero_code_ans_q", 8'(q8a), 8'h00);
        cyc(0, 0, 0, 1);

        // Pre-empt during the fourth SHOW cycle
        cyc(1, 3'b101, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 3'b110, 0, 0);
        chk("preempt_led", 8'(led8), 8'h06);
        for (int k = 0; k < 7; k++) begin
            cyc(0, 0, 0, 0);
            chk("preempt_hold", 8'(led8), 8'h06);
        end
        cyc(0, 0, 0, 0);
        chk("preempt_end", 8'({busy8, led8}), 8'h00);
        repeat (10) cyc(0, 0, 0, 0);
        chk("hold_forever", 8'({busy0, led0}), 8'h0e);
        cyc(0, 0, 0, 1);
        chk("hold_forever_clear", 8'({busy0, led0}), 8'h00);

        // clear beats ans_done during FLASH_ON
        cyc(1, 3'b011, 1, 0);
        cyc(1, 3'b010, 0, 1);
        chk("clr_win_led", 8'({busy8, led8}), 8'h00);
        chk("clr_win_ans_q", 8'(q8a), 8'h03);

        // ans_done held high restarts every cycle
        repeat (3) cyc(1, 3'b100, 1, 0);
        repeat (20) cyc(0, 0, 0, 0);

        // Asynchronous reset in the middle of SHOW
        cyc(1, 3'b101, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", 8'({busy8, led8}), 8'h00);
        chk("async_rst_ans_q", 8'(q8a), 8'h00);
        chk("async_rst_h0", 8'({busy0, led0}), 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 6) == 0, 3'($urandom), 1'($urandom), ($urandom % 30) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
